maxpool_relu: RTL and testbench

Pooling stage between `conv1_layer` and `conv2_layer`. Consumes the three 12-bit signed feature-map streams produced by `conv1_layer` (24×24 per channel, raster order), applies 2×2 stride-2 max pooling followed by ReLU, and emits three 12×12 pooled streams with a single valid strobe for `conv2_layer`.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/maxpool_relu_if.sv | 26 ++
 rtl/maxpool_relu_pool_channel.sv | 47 ++++
 rtl/maxpool_relu.sv | 82 ++++++++
 tb/tb_maxpool_relu.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN definitions for the conv1 -> pool -> conv2 pipeline.
// Holds the default sample width, feature-map dimensions, counter widths,
// the channel count and the signed sample type.
package cnn_pkg;
  localparam int CONV_BIT    = 12;
  localparam int HALF_WIDTH  = 12;
  localparam int HALF_HEIGHT = 12;
  localparam int IN_WIDTH    = 2 * HALF_WIDTH;
  localparam int IN_HEIGHT   = 2 * HALF_HEIGHT;
  localparam int ROW_W       = 5;
  localparam int COL_W       = 5;
  localparam int IDX_W       = 4;
  localparam int NUM_CH      = 3;

  typedef logic signed [CONV_BIT-1:0] sample_t;
endpackage

// File: rtl/maxpool_relu_if.sv
// Stream bundle between conv1_layer and conv2_layer through the pooling stage.
//   valid_in / conv_out_1..3       : input samples, one per channel per valid cycle
//   valid_out_relu / max_value_1..3: pooled+ReLU samples, one-cycle strobe
// master = upstream producer / downstream consumer side, slave = pooling block.
interface maxpool_relu_if #(
  parameter int CONV_BIT = 12
);
  logic                       valid_in;
  logic signed [CONV_BIT-1:0] conv_out_1;
  logic signed [CONV_BIT-1:0] conv_out_2;
  logic signed [CONV_BIT-1:0] conv_out_3;
  logic                       valid_out_relu;
  logic signed [CONV_BIT-1:0] max_value_1;
  logic signed [CONV_BIT-1:0] max_value_2;
  logic signed [CONV_BIT-1:0] max_value_3;

  modport master (
    output valid_in, conv_out_1, conv_out_2, conv_out_3,
    input  valid_out_relu, max_value_1, max_value_2, max_value_3
  );

  modport slave (
    input  valid_in, conv_out_1, conv_out_2, conv_out_3,
    output valid_out_relu, max_value_1, max_value_2, max_value_3
  );
endinterface

// File: rtl/maxpool_relu_pool_channel.sv
// pool_channel: one channel of 2x2/stride-2 max pooling plus ReLU.
//   clk, rst_n  : clock, synchronous active-low reset (output register only)
//   din         : signed input sample
//   store_pair  : even column -> latch din in pair register
//   write_buf   : even row, odd column -> store horizontal max in line buffer
//   emit        : odd row, odd column -> register ReLU(max of 2x2 window)
//   buf_idx     : pooled column index (col >> 1)
//   dout        : pooled result, holds between emits
module pool_channel #(
  parameter int CONV_BIT = cnn_pkg::CONV_BIT,
  parameter int DEPTH    = cnn_pkg::HALF_WIDTH,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [CONV_BIT-1:0] din,
  input  logic                       store_pair,
  input  logic                       write_buf,
  input  logic                       emit,
  input  logic [IDX_W-1:0]           buf_idx,
  output logic signed [CONV_BIT-1:0] dout
);
  import cnn_pkg::*;

  logic signed [CONV_BIT-1:0] p;
  logic signed [CONV_BIT-1:0] line_buf [DEPTH];
  logic signed [CONV_BIT-1:0] m, b, r, relu;

  // p and line_buf are always written before being read within a frame,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (store_pair) p <= din;
    if (write_buf)  line_buf[buf_idx] <= m;
  end

  always_comb begin
    m    = (din > p) ? din : p;
    b    = line_buf[buf_idx];
    r    = (b > m) ? b : m;
    relu = r[CONV_BIT-1] ? '0 : r;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    dout <= '0;
    else if (emit) dout <= relu;
  end
endmodule

// File: rtl/maxpool_relu.sv
// maxpool_relu: 2x2 stride-2 max pool + ReLU over three lockstep channels.
//   clk, rst_n : clock, synchronous active-low reset
//   pool       : slave side of maxpool_relu_if (inputs from conv1, pooled
//                outputs and valid_out_relu strobe to conv2)
// Holds the shared row/col raster counters and drives per-channel controls.
module maxpool_relu #(
  parameter int CONV_BIT    = cnn_pkg::CONV_BIT,
  parameter int HALF_WIDTH  = cnn_pkg::HALF_WIDTH,
  parameter int HALF_HEIGHT = cnn_pkg::HALF_HEIGHT
) (
  input  logic          clk,
  input  logic          rst_n,
  maxpool_relu_if.slave pool
);
  import cnn_pkg::*;

  localparam int CW    = $clog2(2 * HALF_WIDTH);
  localparam int RW    = $clog2(2 * HALF_HEIGHT);
  localparam int IDX_W = $clog2(HALF_WIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(2 * HALF_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(2 * HALF_HEIGHT - 1);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             store_pair, write_buf, emit;
  logic [IDX_W-1:0] buf_idx;
  logic             vld_out;

  logic [NUM_CH-1:0][CONV_BIT-1:0] din_arr;
  logic [NUM_CH-1:0][CONV_BIT-1:0] dout_arr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pool.valid_in) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Pair index is col[0]; row parity picks line-buffer write vs. final compare.
  always_comb begin
    store_pair = pool.valid_in & ~col[0];
    write_buf  = pool.valid_in &  col[0] & ~row[0];
    emit       = pool.valid_in &  col[0] &  row[0];
    buf_idx    = IDX_W'(col >> 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) vld_out <= 1'b0;
    else        vld_out <= emit;
  end

  assign din_arr = {pool.conv_out_3, pool.conv_out_2, pool.conv_out_1};

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    pool_channel #(
      .CONV_BIT (CONV_BIT),
      .DEPTH    (HALF_WIDTH),
      .IDX_W    (IDX_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din_arr[n]),
      .store_pair (store_pair),
      .write_buf  (write_buf),
      .emit       (emit),
      .buf_idx    (buf_idx),
      .dout       (dout_arr[n])
    );
  end

  assign pool.valid_out_relu = vld_out;
  assign pool.max_value_1    = dout_arr[0];
  assign pool.max_value_2    = dout_arr[1];
  assign pool.max_value_3    = dout_arr[2];
endmodule

// File: tb/tb_maxpool_relu.sv
// Self-checking bench for maxpool_relu: scoreboard queue of expected pooled
// triples pushed when the closing sample of a 2x2 window is driven, popped
// when the strobe appears one cycle later.
module tb_maxpool_relu;
  localparam int CB = 12;
  localparam int W  = 24;
  localparam int H  = 24;

  typedef struct { int v1; int v2; int v3; } trip_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  maxpool_relu_if #(.CONV_BIT(CB)) pool ();

  maxpool_relu #(.CONV_BIT(CB), .HALF_WIDTH(12), .HALF_HEIGHT(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pool  (pool.slave)
  );

  int    fr [3][H][W];
  trip_t sb [$];
  trip_t last;
  int    cur_r, cur_c;
  int    n_chk, n_pass;
  int    n_strobe;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int win_relu(int ch, int r, int c);
    int m;
    m = fr[ch][r-1][c-1];
    if (fr[ch][r-1][c] > m) m = fr[ch][r-1][c];
    if (fr[ch][r][c-1]  > m) m = fr[ch][r][c-1];
    if (fr[ch][r][c]    > m) m = fr[ch][r][c];
    return (m < 0) ? 0 : m;
  endfunction

  function automatic int rnd12();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  // One clock: drive at negedge, check 1 time unit after the following posedge.
  task automatic step(input bit v, input bit rst, input int d1, input int d2, input int d3);
    bit    exp_vld;
    trip_t e;
    @(negedge clk);
    rst_n          = ~rst;
    pool.valid_in  = v;
    pool.conv_out_1 = CB'(d1);
    pool.conv_out_2 = CB'(d2);
    pool.conv_out_3 = CB'(d3);
    exp_vld = !rst && v && cur_r[0] && cur_c[0];
    if (exp_vld) begin
      e.v1 = win_relu(0, cur_r, cur_c);
      e.v2 = win_relu(1, cur_r, cur_c);
      e.v3 = win_relu(2, cur_r, cur_c);
      sb.push_back(e);
    end
    if (rst) begin
      cur_r = 0; cur_c = 0;
    end else if (v) begin
      if (cur_c == W-1) begin
        cur_c = 0;
        cur_r = (cur_r == H-1) ? 0 : cur_r + 1;
      end else cur_c++;
    end
    @(posedge clk);
    #1;
    chk("valid_out_relu", int'(pool.valid_out_relu), int'(exp_vld));
    if (rst) begin
      last = '{0, 0, 0};
      chk("rst_max1", int'(pool.max_value_1), 0);
      chk("rst_max2", int'(pool.max_value_2), 0);
      chk("rst_max3", int'(pool.max_value_3), 0);
    end else if (pool.valid_out_relu) begin
      n_strobe++;
      if (sb.size() == 0) chk("scoreboard_empty", 1, 0);
      else begin
        e = sb.pop_front();
        last = e;
        chk("max_value_1", int'(pool.max_value_1), e.v1);
        chk("max_value_2", int'(pool.max_value_2), e.v2);
        chk("max_value_3", int'(pool.max_value_3), e.v3);
      end
    end else begin
      chk("hold_max1", int'(pool.max_value_1), last.v1);
      chk("hold_max2", int'(pool.max_value_2), last.v2);
      chk("hold_max3", int'(pool.max_value_3), last.v3);
    end
  endtask

  // Drive nsamp samples of the current frame from the model's position,
  // with gap_pct percent chance of an idle cycle before each one.
  task automatic run_samples(input int nsamp, input int gap_pct);
    for (int k = 0; k < nsamp; k++) begin
      while (int'($urandom_range(99)) < gap_pct)
        step(1'b0, 1'b0, rnd12(), rnd12(), rnd12());
      step(1'b1, 1'b0, fr[0][cur_r][cur_c], fr[1][cur_r][cur_c], fr[2][cur_r][cur_c]);
    end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int n = 0; n < 3; n++) fr[n][r][c] = r*W + c + n;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int n = 0; n < 3; n++) fr[n][r][c] = rnd12();
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b1, rnd12(), rnd12(), rnd12());
  endtask

  int s0;

  initial begin
    n_chk = 0; n_pass = 0; n_strobe = 0;
    cur_r = 0; cur_c = 0;
    last = '{0, 0, 0};
    rst_n = 1'b0;
    pool.valid_in = 1'b0;
    pool.conv_out_1 = '0; pool.conv_out_2 = '0; pool.conv_out_3 = '0;

    // Reset held with valid_in high and random data: no strobe, outputs 0.
    do_reset(4);

    // Continuous ramp frame.
    fill_ramp();
    s0 = n_strobe;
    run_samples(W*H, 0);
    chk("ramp_strobes", n_strobe - s0, 144);
    chk("ramp_first_direct", last.v1, 23*24 + 23);

    // ReLU / sign frame.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        fr[0][r][c] = -5;
        fr[1][r][c] = rnd12();
        fr[2][r][c] = -2048;
      end
    fr[1][0][0] = -2048; fr[1][0][1] = -1; fr[1][1][0] = 5; fr[1][1][1] = -300;
    run_samples(2*W, 0);
    chk("sign_ch1_00", last.v1, 0);
    chk("sign_ch2_00_first", sb.size(), 0);
    run_samples(W*H - 2*W, 0);
    chk("sign_ch3_last", int'(pool.max_value_3), 0);

    // Ramp with random idle gaps.
    fill_ramp();
    s0 = n_strobe;
    run_samples(W*H, 40);
    chk("gap_strobes", n_strobe - s0, 144);

    // Mid-frame reset, then a full ramp frame.
    fill_rand();
    run_samples(300, 10);
    do_reset(2);
    step(1'b0, 1'b0, 0, 0, 0);
    fill_ramp();
    s0 = n_strobe;
    run_samples(W*H, 0);
    chk("midrst_strobes", n_strobe - s0, 144);

    // Back-to-back frames: random then ramp, no gap.
    fill_rand();
    s0 = n_strobe;
    run_samples(W*H, 0);
    fill_ramp();
    run_samples(W*H, 0);
    chk("b2b_strobes", n_strobe - s0, 288);
    chk("b2b_last_ch2", int'(pool.max_value_2), 23*24 + 23 + 1);

    step(1'b0, 1'b0, 0, 0, 0);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
